icache_refill: RTL and testbench

- Sits between the blocking instruction cache and the memory/L2 side.
- On a cache miss request it issues one block-aligned read to memory and collects BLOCK_WIDTH/MEM_BUS_WIDTH response beats into a full block.
- It then presents the block to the cache with a single-cycle ready pulse.
- One refill is in flight at a time, matching the blocking cache.

---
 rtl/icache_pkg.sv | 30 +++
 rtl/icache_refill_sva.sv | 37 +++
 rtl/icache_refill.sv | 101 ++++++++++
 tb/tb_icache_refill.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared fetch-path definitions: refill FSM states and block/beat geometry helpers.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } refill_state_t;

  function automatic int beats(input int block_width, input int bus_width);
    return block_width / bus_width;
  endfunction

  function automatic int cnt_bits(input int block_width, input int bus_width);
    return $clog2(block_width / bus_width);
  endfunction

  function automatic int align_bits(input int block_width);
    return $clog2(block_width / 8);
  endfunction

  // A refill needs a whole, power-of-two number of beats (at least two).
  function automatic bit beats_ok(input int block_width, input int bus_width);
    int b;
    b = block_width / bus_width;
    return (block_width % bus_width == 0) && (b >= 2) && ((b & (b - 1)) == 0);
  endfunction

endpackage

// File: rtl/icache_refill_sva.sv
// Protocol and invariant checks for icache_refill; compiled only with INCLUDE_SVAS.
`ifdef INCLUDE_SVAS
module icache_refill_sva
  import icache_pkg::*;
#(
  parameter int ADDRESS_BITS = 32
) (
  input logic                    clk,
  input logic                    rst,
  input refill_state_t           state,
  input logic                    valid_i,
  input logic                    ready_o,
  input logic                    mem_req_valid_o,
  input logic                    mem_req_ready_i,
  input logic [ADDRESS_BITS-1:0] mem_req_addr_o,
  input logic                    mem_resp_valid_i
);

  // Upstream protocol violations are reported but the block tolerates them.
  a_valid_only_idle: assert property (@(posedge clk) disable iff (rst)
    valid_i |-> state == IDLE)
    else $warning("icache_refill: valid_i while refill in progress");

  a_resp_only_fill: assert property (@(posedge clk) disable iff (rst)
    mem_resp_valid_i |-> !(state == IDLE || state == REQ))
    else $warning("icache_refill: response beat with no request outstanding");

  a_ready_pulse: assert property (@(posedge clk) disable iff (rst)
    ready_o |=> !ready_o)
    else $error("icache_refill: ready_o longer than one cycle");

  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (mem_req_valid_o && !mem_req_ready_i) |=> (mem_req_valid_o && $stable(mem_req_addr_o)))
    else $error("icache_refill: request dropped or address changed before handshake");

endmodule
`endif

// File: rtl/icache_refill.sv
// Blocking I-cache refill engine: one aligned memory read, beats assembled into a block.
module icache_refill
  import icache_pkg::*;
#(
  parameter int ADDRESS_BITS  = 32,
  parameter int BLOCK_WIDTH   = 256,
  parameter int MEM_BUS_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic [ADDRESS_BITS-1:0]  address_i,
  output logic                     ready_o,
  output logic [BLOCK_WIDTH-1:0]   data_o,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic [ADDRESS_BITS-1:0]  mem_req_addr_o,
  input  logic                     mem_resp_valid_i,
  input  logic [MEM_BUS_WIDTH-1:0] mem_resp_data_i,
  output logic                     busy_o
);

  localparam int BEATS      = beats(BLOCK_WIDTH, MEM_BUS_WIDTH);
  localparam int CNT_BITS   = cnt_bits(BLOCK_WIDTH, MEM_BUS_WIDTH);
  localparam int ALIGN_BITS = align_bits(BLOCK_WIDTH);

  localparam logic [CNT_BITS-1:0]     LAST_BEAT  = CNT_BITS'(BEATS - 1);
  localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~(ADDRESS_BITS'((64'd1 << ALIGN_BITS) - 64'd1));

  if (!beats_ok(BLOCK_WIDTH, MEM_BUS_WIDTH)) begin : g_bad_geometry
    $error("icache_refill: BLOCK_WIDTH/MEM_BUS_WIDTH must be a power of two >= 2");
  end

  refill_state_t       state;
  refill_state_t       state_next;
  logic [CNT_BITS-1:0] cnt;
  logic                take_miss;
  logic                take_beat;

  assign take_miss = (state == IDLE) && valid_i;
  assign take_beat = (state == FILL) && mem_resp_valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (valid_i)         state_next = REQ;
      REQ:     if (mem_req_ready_i) state_next = FILL;
      FILL:    if (mem_resp_valid_i && (cnt == LAST_BEAT)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode the registered state only, so ready_o cannot coincide with a new miss.
  assign ready_o         = (state == DONE);
  assign mem_req_valid_o = (state == REQ);
  assign busy_o          = (state != IDLE);

  // data_o is deliberately not cleared on a new miss: stale words persist until overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      mem_req_addr_o <= '0;
      data_o         <= '0;
    end else begin
      if (take_miss) begin
        mem_req_addr_o <= address_i & ALIGN_MASK;
        cnt            <= '0;
      end
      if (take_beat) begin
        data_o[cnt*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] <= mem_resp_data_i;
        cnt                                        <= cnt + CNT_BITS'(1);
      end
    end
  end

`ifdef INCLUDE_SVAS
  icache_refill_sva #(
    .ADDRESS_BITS (ADDRESS_BITS)
  ) u_sva (
    .clk              (clk),
    .rst              (rst),
    .state            (state),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i)
  );
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: cycle table for basic/back-to-back refills, plus corner sequences.
module tb_icache_refill;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic [31:0]  address_i;
  logic         ready_o;
  logic [255:0] data_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [31:0]  mem_req_addr_o;
  logic         mem_resp_valid_i;
  logic [63:0]  mem_resp_data_i;
  logic         busy_o;

  int n_vec = 0;
  int n_bad = 0;

  icache_refill #(
    .ADDRESS_BITS  (32),
    .BLOCK_WIDTH   (256),
    .MEM_BUS_WIDTH (64)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_i          (valid_i),
    .address_i        (address_i),
    .ready_o          (ready_o),
    .data_o           (data_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         valid;
    logic [31:0]  addr;
    logic         req_ready;
    logic         resp_valid;
    logic [63:0]  resp_data;
    logic         e_ready;
    logic         e_req_valid;
    logic         e_busy;
    logic [31:0]  e_addr;
    logic [255:0] e_data;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  // Beat 0 is the lowest word of the block.
  function automatic logic [255:0] blk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
    return {rep(b3), rep(b2), rep(b1), rep(b0)};
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] a,
                              input logic rr, input logic rv, input logic [63:0] rd,
                              input logic er, input logic erv, input logic eb,
                              input logic [31:0] ea, input logic [255:0] ed);
    vec_t t;
    t.rst = r; t.valid = v; t.addr = a; t.req_ready = rr; t.resp_valid = rv; t.resp_data = rd;
    t.e_ready = er; t.e_req_valid = erv; t.e_busy = eb; t.e_addr = ea; t.e_data = ed;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic er, input logic erv, input logic eb,
                         input logic [31:0] ea, input logic [255:0] ed);
    chk({tag, ".ready"},     256'(ready_o),         256'(er));
    chk({tag, ".req_valid"}, 256'(mem_req_valid_o), 256'(erv));
    chk({tag, ".busy"},      256'(busy_o),          256'(eb));
    chk({tag, ".req_addr"},  256'(mem_req_addr_o),  256'(ea));
    chk({tag, ".data"},      data_o,                ed);
  endtask

  // Advance to the middle of the next cycle and return all inputs to idle.
  task automatic cyc();
    @(negedge clk);
    rst = 1'b0; valid_i = 1'b0; address_i = '0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
  endtask

  initial begin
    logic [255:0] blk_a, blk_b, blk_g, blk_r;
    logic         pat [7];
    logic [7:0]   gap_bytes [4];
    int           bi;

    blk_a = blk(8'h00, 8'h11, 8'h22, 8'h33);
    blk_b = blk(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    blk_g = blk(8'h44, 8'h55, 8'h66, 8'h77);
    blk_r = blk(8'h01, 8'h02, 8'h03, 8'h04);

    //          rst valid addr          rr  rv  data          rdy rv  busy addr          data
    tbl[0]  = mk(0, 1, 32'h0000_1234,  0,  0, '0,           0,  0,  0,  32'h0,         '0);
    tbl[1]  = mk(0, 0, 32'h0,          1,  0, '0,           0,  1,  1,  32'h0000_1220, '0);
    tbl[2]  = mk(0, 0, 32'h0,          0,  1, rep(8'h00),   0,  0,  1,  32'h0000_1220, '0);
    tbl[3]  = mk(0, 0, 32'h0,          0,  1, rep(8'h11),   0,  0,  1,  32'h0000_1220, '0);
    tbl[4]  = mk(0, 0, 32'h0,          0,  1, rep(8'h22),   0,  0,  1,  32'h0000_1220, blk(8'h00, 8'h11, 8'h00, 8'h00));
    tbl[5]  = mk(0, 0, 32'h0,          0,  1, rep(8'h33),   0,  0,  1,  32'h0000_1220, blk(8'h00, 8'h11, 8'h22, 8'h00));
    tbl[6]  = mk(0, 0, 32'h0,          0,  0, '0,           1,  0,  1,  32'h0000_1220, blk_a);
    tbl[7]  = mk(0, 1, 32'h0000_201F,  0,  0, '0,           0,  0,  0,  32'h0000_1220, blk_a);
    tbl[8]  = mk(0, 0, 32'h0,          1,  0, '0,           0,  1,  1,  32'h0000_2000, blk_a);
    tbl[9]  = mk(0, 0, 32'h0,          0,  1, rep(8'hAA),   0,  0,  1,  32'h0000_2000, blk_a);
    tbl[10] = mk(0, 0, 32'h0,          0,  1, rep(8'hBB),   0,  0,  1,  32'h0000_2000, blk(8'hAA, 8'h11, 8'h22, 8'h33));
    tbl[11] = mk(0, 0, 32'h0,          0,  1, rep(8'hCC),   0,  0,  1,  32'h0000_2000, blk(8'hAA, 8'hBB, 8'h22, 8'h33));
    tbl[12] = mk(0, 0, 32'h0,          0,  1, rep(8'hDD),   0,  0,  1,  32'h0000_2000, blk(8'hAA, 8'hBB, 8'hCC, 8'h33));
    tbl[13] = mk(0, 0, 32'h0,          0,  0, '0,           1,  0,  1,  32'h0000_2000, blk_b);
    tbl[14] = mk(0, 0, 32'h0,          0,  0, '0,           0,  0,  0,  32'h0000_2000, blk_b);

    rst = 1'b1; valid_i = 1'b0; address_i = '0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic refill followed immediately by a back-to-back refill.
    for (int i = 0; i < 15; i++) begin
      cyc();
      exp_out($sformatf("tbl%0d", i), tbl[i].e_ready, tbl[i].e_req_valid, tbl[i].e_busy,
              tbl[i].e_addr, tbl[i].e_data);
      rst = tbl[i].rst; valid_i = tbl[i].valid; address_i = tbl[i].addr;
      mem_req_ready_i = tbl[i].req_ready; mem_resp_valid_i = tbl[i].resp_valid;
      mem_resp_data_i = tbl[i].resp_data;
    end

    // Request backpressure: three stalled cycles before the handshake.
    cyc(); valid_i = 1'b1; address_i = 32'h0000_1234;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("bp%0d.req_valid", k), 256'(mem_req_valid_o), 256'(1'b1));
      chk($sformatf("bp%0d.req_addr", k),  256'(mem_req_addr_o),  256'(32'h0000_1220));
      chk($sformatf("bp%0d.busy", k),      256'(busy_o),          256'(1'b1));
      mem_req_ready_i = (k == 4);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("bp_fill%0d.ready", k), 256'(ready_o), 256'(1'b0));
      chk($sformatf("bp_fill%0d.req_valid", k), 256'(mem_req_valid_o), 256'(1'b0));
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = rep(8'(k * 8'h11));
    end
    cyc(); exp_out("bp_done", 1'b1, 1'b0, 1'b1, 32'h0000_1220, blk_a);
    cyc(); exp_out("bp_idle", 1'b0, 1'b0, 1'b0, 32'h0000_1220, blk_a);

    // Beat gaps: valid pattern 1,0,0,1,1,0,1 with junk on the bus during gaps.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    gap_bytes = '{8'h44, 8'h55, 8'h66, 8'h77};
    bi = 0;
    valid_i = 1'b1; address_i = 32'h0000_307F;
    cyc(); mem_req_ready_i = 1'b1;
    for (int j = 0; j < 7; j++) begin
      cyc();
      chk($sformatf("gap%0d.ready", j), 256'(ready_o), 256'(1'b0));
      chk($sformatf("gap%0d.busy", j),  256'(busy_o),  256'(1'b1));
      mem_resp_valid_i = pat[j];
      if (pat[j]) begin
        mem_resp_data_i = rep(gap_bytes[bi]);
        bi++;
      end else begin
        mem_resp_data_i = {4{16'hDEAD}};
      end
    end
    cyc(); exp_out("gap_done", 1'b1, 1'b0, 1'b1, 32'h0000_3060, blk_g);
    cyc(); exp_out("gap_idle", 1'b0, 1'b0, 1'b0, 32'h0000_3060, blk_g);

    // Spurious inputs: stray beat in REQ, beat on the handshake cycle, second miss in FILL.
    valid_i = 1'b1; address_i = 32'h0000_1234;
    cyc(); chk("sp_req1.req_valid", 256'(mem_req_valid_o), 256'(1'b1));
    mem_resp_valid_i = 1'b1; mem_resp_data_i = rep(8'hEE);
    cyc(); chk("sp_req2.req_valid", 256'(mem_req_valid_o), 256'(1'b1));
    mem_req_ready_i = 1'b1; mem_resp_valid_i = 1'b1; mem_resp_data_i = rep(8'hEE);
    for (int k = 0; k < 4; k++) begin
      cyc();
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = rep(8'(k * 8'h11));
      if (k == 1) begin
        valid_i = 1'b1; address_i = 32'h0000_5000;
      end
    end
    cyc(); exp_out("sp_done", 1'b1, 1'b0, 1'b1, 32'h0000_1220, blk_a);
    cyc(); exp_out("sp_idle", 1'b0, 1'b0, 1'b0, 32'h0000_1220, blk_a);
    cyc(); chk("sp_after.req_valid", 256'(mem_req_valid_o), 256'(1'b0));

    // Reset mid-FILL after two beats, stale beats afterwards, then a fresh refill.
    valid_i = 1'b1; address_i = 32'h0000_1234;
    cyc(); mem_req_ready_i = 1'b1;
    cyc(); mem_resp_valid_i = 1'b1; mem_resp_data_i = rep(8'h99);
    cyc(); mem_resp_valid_i = 1'b1; mem_resp_data_i = rep(8'h88);
    cyc(); exp_out("rs_mid", 1'b0, 1'b0, 1'b1, 32'h0000_1220, blk(8'h99, 8'h88, 8'h22, 8'h33));
    rst = 1'b1; mem_resp_valid_i = 1'b1; mem_resp_data_i = rep(8'h77);
    cyc(); exp_out("rs_zero", 1'b0, 1'b0, 1'b0, 32'h0, '0);
    mem_resp_valid_i = 1'b1; mem_resp_data_i = rep(8'h66);
    cyc(); exp_out("rs_stale", 1'b0, 1'b0, 1'b0, 32'h0, '0);
    valid_i = 1'b1; address_i = 32'h0000_0040;
    cyc(); exp_out("rs_req", 1'b0, 1'b1, 1'b1, 32'h0000_0040, '0);
    mem_req_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = rep(8'(k));
    end
    cyc(); exp_out("rs_done", 1'b1, 1'b0, 1'b1, 32'h0000_0040, blk_r);
    cyc(); exp_out("rs_idle", 1'b0, 1'b0, 1'b0, 32'h0000_0040, blk_r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
